laser_seq: RTL and testbench
============================

LASER_SEQ -- requirements
Module: laser_seq

Interface
REQ-001 Parameter NPTS, 40, number of points per job; the SHALL-fixed engine load length.
REQ-002 Parameter TMO_W, 16, width of the engine-wait timeout counter; the timeout limit SHALL be 2^TMO_W-1 cycles.
REQ-003 CLK  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 in_valid/in_ready  input/output  1/1  host point handshake; a point SHALL transfer when both are high at a rising edge.
REQ-006 in_x/in_y  input  4/4  host point coordinates.
REQ-007 eng_rst  output  1  active-high reset to the laser engine.
REQ-008 eng_x/eng_y  output  4/4  point stream to the engine; registered.
REQ-009 eng_done  input  1  engine completion pulse.
REQ-010 eng_c1x/eng_c1y/eng_c2x/eng_c2y  input  4 each  engine circle centres, valid while eng_done=1.
REQ-011 res_valid/res_ready  output/input  1/1  result handshake.
REQ-012 res_c1x/res_c1y/res_c2x/res_c2y  output  4 each  captured centres.
REQ-013 res_err  output  1  timeout flag for the presented result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL, KICK, STREAM, WAIT and RESULT.
REQ-016 IDLE: in_ready=1; the first accepted point SHALL be written to buffer entry 0 and the FSM SHALL move to FILL.
REQ-017 FILL: in_ready=1; each accepted point SHALL be written to entry wr_cnt and increment wr_cnt; a cycle without a handshake SHALL hold all state.
REQ-018 In the cycle the NPTS-th point is accepted, the FSM SHALL go to KICK; in_ready SHALL be 0 in KICK, STREAM, WAIT and RESULT, and in_valid SHALL be ignored in those states.
REQ-019 KICK lasts exactly 1 cycle with eng_rst=1; eng_rst SHALL be 0 in all other states after reset.
REQ-020 STREAM lasts exactly NPTS cycles; in the k-th STREAM cycle (k=0..NPTS-1), eng_x/eng_y SHALL equal buffer entry k.
REQ-021 The first STREAM cycle SHALL be the cycle immediately after KICK.
REQ-022 eng_x/eng_y SHALL be 0 outside STREAM.
REQ-023 After the last STREAM cycle the FSM SHALL enter WAIT and clear the timeout counter.
REQ-024 WAIT: in the cycle eng_done=1, the four engine centres SHALL be captured into res_c*, res_err SHALL be set to 0, and the FSM SHALL go to RESULT.
REQ-025 WAIT timeout: if the counter reaches 2^TMO_W-1 with eng_done=0, res_c* SHALL be set to 0, res_err SHALL be set to 1, and the FSM SHALL go to RESULT.
REQ-026 If eng_done=1 coincides with the timeout cycle, the FSM SHALL take the done path (res_err=0).
REQ-027 eng_done asserted outside WAIT SHALL be ignored.
REQ-028 RESULT: res_valid=1 and res_* SHALL be held stable until res_ready=1; the FSM SHALL then go to IDLE with res_valid=0 in the following cycle.
REQ-029 res_ready outside RESULT SHALL be ignored.
REQ-030 wr_cnt and the stream counter SHALL be 6 bits and SHALL clear to 0 on leaving FILL and STREAM respectively; they SHALL never exceed NPTS-1.
REQ-031 Back-to-back jobs: a new point SHALL be acceptable in the cycle after the RESULT handshake; the buffer SHALL not need clearing, since every entry is rewritten per job.

Reset
REQ-032 While RST=0, the FSM SHALL be IDLE and the counters SHALL be 0.
REQ-033 While RST=0, eng_rst SHALL be 1, holding the engine in reset.
REQ-034 While RST=0, in_ready, res_valid, res_err, busy, eng_x, eng_y and res_c* SHALL be 0.
REQ-035 Assertion of RST mid-job (any state) SHALL immediately abort the job with the values of REQ-032 to REQ-034; no partial result SHALL be presented.
REQ-036 In IDLE after RST deasserts, eng_rst SHALL be 0 and in_ready SHALL be 1.
REQ-037 Buffer contents need not be reset.

Verification
REQ-038 Sequence: 40 points (x=k%16, y=(3k)%16) with in_valid held high -> 40 consecutive accepts, 1-cycle eng_rst pulse, then eng_x/eng_y replay the same 40 points in order on the next 40 cycles.
REQ-039 Gapped input: in_valid toggling 1/0 -> 40 accepts over 80 cycles, wr_cnt holds on idle cycles, and the stream is identical to REQ-038.
REQ-040 Engine model pulses eng_done with c1=(3,4), c2=(10,11), and res_ready is held low for 5 cycles -> res_valid=1 with res_c*=3,4,10,11 and res_err=0 stable for 5 cycles, then IDLE.
REQ-041 eng_done never arrives (TMO_W reduced to 4 for the test) -> RESULT entered 15 cycles after WAIT entry, with res_err=1 and res_c*=0.
REQ-042 RST pulsed low during STREAM at k=20 -> eng_rst=1, busy=0 and res_valid=0 immediately; a subsequent full job completes correctly.
REQ-043 eng_done pulsed during FILL and during the timeout cycle -> the FILL pulse has no effect, and the timeout-cycle pulse yields res_err=0.

Source files
------------

// File: rtl/laser_seq.sv
// laser_seq: collects a job of NPTS host points into a local buffer, pulses the
// engine reset, replays the points to the engine one per cycle, then waits for the
// engine's circle centres (or a timeout) and presents them as a result.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready are
// both high; valid and the data it qualifies stay stable until that edge, and ready
// may be high before valid. On the host side, in_ready is the sequencer's ready.
// On the result side, res_valid is the sequencer's valid.
`timescale 1ns/1ps
module laser_seq #(
  parameter int NPTS  = 40,
  parameter int TMO_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  output logic             eng_rst,
  output logic [3:0]       eng_x,
  output logic [3:0]       eng_y,
  input  logic             eng_done,
  input  logic [3:0]       eng_c1x,
  input  logic [3:0]       eng_c1y,
  input  logic [3:0]       eng_c2x,
  input  logic [3:0]       eng_c2y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_c1x,
  output logic [3:0]       res_c1y,
  output logic [3:0]       res_c2x,
  output logic [3:0]       res_c2y,
  output logic             res_err,
  output logic             busy,
  output logic [2:0]       dbg_state,
  output logic [5:0]       dbg_wr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    KICK   = 3'd2,
    STREAM = 3'd3,
    WAIT   = 3'd4,
    RESULT = 3'd5
  } state_t;

  localparam logic [5:0]       LAST_IDX = 6'(NPTS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  state_t           state;
  logic [5:0]       wr_cnt;
  logic [5:0]       st_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  logic [5:0]       rd_idx;
  logic             accept;
  logic [7:0]       pt_mem [0:NPTS-1];

  // A point transfers only while the sequencer is collecting a job.
  assign accept  = in_valid && in_ready && ((state == IDLE) || (state == FILL));
  assign tmo_nxt = tmo_cnt + TMO_W'(1);

  // Buffer entry to load into eng_x/eng_y on the coming edge: entry 0 from KICK,
  // entry k+1 while streaming entry k (clamped on the last point, unused there).
  always_comb begin
    rd_idx = 6'd0;
    if ((state == STREAM) && (st_cnt != LAST_IDX)) begin
      rd_idx = st_cnt + 6'd1;
    end
  end

  // Point buffer; every entry is rewritten by each job so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      pt_mem[wr_cnt] <= {in_x, in_y};
    end
  end

  // Job sequencer with all outputs registered alongside the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      wr_cnt    <= 6'd0;
      st_cnt    <= 6'd0;
      tmo_cnt   <= '0;
      in_ready  <= 1'b0;
      eng_rst   <= 1'b1;
      eng_x     <= 4'd0;
      eng_y     <= 4'd0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_c1x   <= 4'd0;
      res_c1y   <= 4'd0;
      res_c2x   <= 4'd0;
      res_c2y   <= 4'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          eng_rst  <= 1'b0;
          if (accept) begin
            state  <= FILL;
            wr_cnt <= 6'd1;
            busy   <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            if (wr_cnt == LAST_IDX) begin
              state    <= KICK;
              wr_cnt   <= 6'd0;
              in_ready <= 1'b0;
              eng_rst  <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 6'd1;
            end
          end
        end
        KICK: begin
          state   <= STREAM;
          eng_rst <= 1'b0;
          st_cnt  <= 6'd0;
          {eng_x, eng_y} <= pt_mem[rd_idx];
        end
        STREAM: begin
          if (st_cnt == LAST_IDX) begin
            state   <= WAIT;
            st_cnt  <= 6'd0;
            tmo_cnt <= '0;
            eng_x   <= 4'd0;
            eng_y   <= 4'd0;
          end else begin
            st_cnt <= st_cnt + 6'd1;
            {eng_x, eng_y} <= pt_mem[rd_idx];
          end
        end
        WAIT: begin
          // A done pulse wins over a timeout landing in the same cycle.
          if (eng_done) begin
            state     <= RESULT;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_c1x   <= eng_c1x;
            res_c1y   <= eng_c1y;
            res_c2x   <= eng_c2x;
            res_c2y   <= eng_c2y;
          end else if (tmo_nxt == TMO_MAX) begin
            state     <= RESULT;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_c1x   <= 4'd0;
            res_c1y   <= 4'd0;
            res_c2x   <= 4'd0;
            res_c2y   <= 4'd0;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state  = state;
  assign dbg_wr_cnt = wr_cnt;

endmodule

// File: tb/tb_laser_seq.sv
// Directed bench for laser_seq: inputs are driven and outputs sampled on the
// falling clock edge; expected stream points are queued as they are sent.
`timescale 1ns/1ps
module tb_laser_seq;

  localparam int NPTS = 40;
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_KICK = 3'd2,
                         S_STREAM = 3'd3, S_WAIT = 3'd4, S_RESULT = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [3:0] in_x = 4'd0, in_y = 4'd0;
  logic       eng_rst;
  logic [3:0] eng_x, eng_y;
  logic       eng_done = 1'b0;
  logic [3:0] eng_c1x = 4'hf, eng_c1y = 4'hf, eng_c2x = 4'hf, eng_c2y = 4'hf;
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic       res_err, busy;
  logic [2:0] dbg_state;
  logic [5:0] dbg_wr_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  laser_seq #(.NPTS(NPTS), .TMO_W(4)) dut (
    .CLK(clk), .RST(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .eng_rst(eng_rst), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
    .eng_c1x(eng_c1x), .eng_c1y(eng_c1y), .eng_c2x(eng_c2x), .eng_c2y(eng_c2y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_err(res_err), .busy(busy), .dbg_state(dbg_state), .dbg_wr_cnt(dbg_wr_cnt)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Sends NPTS points x=(k+off)%16, y=(3k+off)%16; optional gaps and a stray done pulse.
  task automatic fill_job(input int off, input bit gapped, input int done_at);
    chk("fill_start_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < NPTS; k++) begin
      in_valid = 1'b1;
      in_x = 4'((k + off) % 16);
      in_y = 4'((3 * k + off) % 16);
      exp_q.push_back({in_x, in_y});
      chk("fill_ready", 32'(in_ready), 32'd1);
      if (k == done_at) eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      if (k == done_at) begin
        chk("stray_done_state", 32'(dbg_state), 32'(S_FILL));
        chk("stray_done_valid", 32'(res_valid), 32'd0);
      end
      if (gapped && k < NPTS - 1) begin
        in_valid = 1'b0;
        chk("gap_wr_cnt_pre", 32'(dbg_wr_cnt), 32'(k + 1));
        tick();
        chk("gap_wr_cnt_hold", 32'(dbg_wr_cnt), 32'(k + 1));
        chk("gap_state", 32'(dbg_state), 32'(S_FILL));
      end
    end
    in_valid = 1'b0;
    in_x = 4'd0;
    in_y = 4'd0;
  endtask

  // Checks the KICK cycle and the first n STREAM cycles against the queue.
  task automatic kick_stream(input int n);
    logic [7:0] e;
    chk("kick_state", 32'(dbg_state), 32'(S_KICK));
    chk("kick_eng_rst", 32'(eng_rst), 32'd1);
    chk("kick_in_ready", 32'(in_ready), 32'd0);
    chk("kick_eng_xy", 32'({eng_x, eng_y}), 32'd0);
    chk("kick_wr_cnt", 32'(dbg_wr_cnt), 32'd0);
    tick();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      chk("stream_state", 32'(dbg_state), 32'(S_STREAM));
      chk("stream_eng_rst", 32'(eng_rst), 32'd0);
      chk("stream_xy", 32'({eng_x, eng_y}), 32'(e));
      tick();
    end
    if (n == NPTS) begin
      chk("wait_entry_state", 32'(dbg_state), 32'(S_WAIT));
      chk("wait_entry_xy", 32'({eng_x, eng_y}), 32'd0);
    end
  endtask

  // Stays in WAIT for dly cycles, then optionally pulses done with the given centres.
  task automatic engine(input int dly, input bit pulse, input logic [15:0] c);
    for (int i = 0; i < dly; i++) begin
      chk("wait_state", 32'(dbg_state), 32'(S_WAIT));
      chk("wait_res_valid", 32'(res_valid), 32'd0);
      tick();
    end
    if (pulse) begin
      eng_done = 1'b1;
      {eng_c1x, eng_c1y, eng_c2x, eng_c2y} = c;
      tick();
      eng_done = 1'b0;
      {eng_c1x, eng_c1y, eng_c2x, eng_c2y} = 16'hffff;
    end
  endtask

  // Holds res_ready low for hold cycles checking a stable result, then hands it off.
  task automatic take_result(input int hold, input logic [15:0] c, input logic err);
    for (int i = 0; i <= hold; i++) begin
      chk("res_state", 32'(dbg_state), 32'(S_RESULT));
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_centres", 32'({res_c1x, res_c1y, res_c2x, res_c2y}), 32'(c));
      chk("res_err", 32'(res_err), 32'(err));
      chk("res_in_ready", 32'(in_ready), 32'd0);
      if (i < hold) tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_res_state", 32'(dbg_state), 32'(S_IDLE));
    chk("post_res_valid", 32'(res_valid), 32'd0);
    chk("post_res_ready", 32'(in_ready), 32'd1);
    chk("post_res_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_eng_rst", 32'(eng_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_eng_xy", 32'({eng_x, eng_y}), 32'd0);
    chk("rst_res_c", 32'({res_c1x, res_c1y, res_c2x, res_c2y}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_eng_rst", 32'(eng_rst), 32'd0);

    // Job A: continuous points, done after 3 WAIT cycles, result held 5 cycles.
    fill_job(0, 1'b0, -1);
    chk("job_a_busy", 32'(busy), 32'd1);
    kick_stream(NPTS);
    engine(3, 1'b1, 16'h34ab);
    take_result(5, 16'h34ab, 1'b0);

    // Job B: back-to-back, gapped input, res_ready high while not in RESULT.
    res_ready = 1'b1;
    fill_job(0, 1'b1, -1);
    res_ready = 1'b0;
    kick_stream(NPTS);
    engine(0, 1'b1, 16'h912e);
    take_result(2, 16'h912e, 1'b0);

    // Job C: stray done during FILL, then the engine never answers.
    fill_job(2, 1'b0, 10);
    kick_stream(NPTS);
    engine(15, 1'b0, 16'h0000);
    take_result(1, 16'h0000, 1'b1);

    // Job D: done arrives exactly in the timeout cycle.
    fill_job(5, 1'b0, -1);
    kick_stream(NPTS);
    engine(14, 1'b1, 16'h1234);
    take_result(0, 16'h1234, 1'b0);

    // Job E: reset mid-stream at k=20.
    fill_job(9, 1'b0, -1);
    kick_stream(20);
    rst_n = 1'b0;
    #1;
    chk("abort_eng_rst", 32'(eng_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_eng_xy", 32'({eng_x, eng_y}), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rerun_in_ready", 32'(in_ready), 32'd1);
    chk("rerun_eng_rst", 32'(eng_rst), 32'd0);

    // Job F: full job after the abort.
    fill_job(11, 1'b0, -1);
    kick_stream(NPTS);
    engine(5, 1'b1, 16'h6789);
    take_result(0, 16'h6789, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
